serial_subtractor: RTL and testbench

//  - Bit-serial W-bit subtractor: diff = a - b, computed LSB-first, one bit per clock.
//  - Uses one full-subtractor cell and a borrow flip-flop.
//  - Sits beside the combinational adder datapath as the low-area subtract engine for the ALU.
//  - Start/busy/done handshake to a controlling sequencer.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_fs.sv | 16 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width,
// and the counter-width helper.
package serial_subtractor_pkg;

  localparam int unsigned SS_WIDTH_DFLT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count 0..w-1 RUN cycles.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - b_in, with borrow out.
module full_subtractor (
  output logic d,
  output logic b_out,
  input  logic x,
  input  logic y,
  input  logic b_in
);

  logic w_xy;

  assign w_xy  = x ^ y;
  assign d     = w_xy ^ b_in;
  assign b_out = (~x & y) | (~w_xy & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first through a single full-subtractor cell.
// The result is committed to the output registers on the edge leaving DONE.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SS_WIDTH_DFLT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_brw;
  logic               r_sign_a;
  logic               r_sign_b;

  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_ovf;

  logic               w_d;
  logic               w_bo;

  full_subtractor u_fs (
    .d     (w_d),
    .b_out (w_bo),
    .x     (r_a[0]),
    .y     (r_b[0]),
    .b_in  (r_brw)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/result shift registers, borrow chain and sign snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_brw    <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_cnt    <= '0;
      r_brw    <= 1'b0;
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= b[WIDTH-1];
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_brw <= w_bo;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Handshake and held result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_diff   <= r_res;
        r_borrow <= r_brw;
        r_ovf    <= (r_sign_a ^ r_sign_b) & (r_res[WIDTH-1] ^ r_sign_a);
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] md, output logic mbo,
                                output logic mov);
    longint sa;
    longint sb;
    longint sr;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    sr  = sa - sb;
    md  = ma - mb;
    mbo = (ma < mb);
    mov = (sr > SMAX) || (sr < SMIN);
  endfunction

  // Called at a negedge; returns negedges elapsed until done is seen.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
    start = 1'b1;
    a     = ia;
    b     = ib;
    lat   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) break;
    end
    if (!done) chk("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           lat;
    model(ia, ib, ed, eb, eo);
    run_op(ia, ib, lat);
    chk({tag, "_diff"}, 64'(diff), 64'(ed));
    chk({tag, "_borrow"}, 64'(borrow_out), 64'(eb));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    chk({tag, "_lat"}, 64'(lat), 64'(W + 2));
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_diff", 64'(diff), 64'(0));
    chk("rst_borrow", 64'(borrow_out), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    // 5 - 3 with latency, busy and pulse-width checks.
    start = 1'b1; a = 32'd5; b = 32'd3; lat = 0;
    @(negedge clock); lat++; start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'(1));
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock); lat++;
    end
    chk("lat_5_3", 64'(lat), 64'(34));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("diff_5_3", 64'(diff), 64'h2);
    chk("borrow_5_3", 64'(borrow_out), 64'(0));
    chk("ovf_5_3", 64'(overflow), 64'(0));
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("diff_held", 64'(diff), 64'h2);

    check_op("zero_minus_one", 32'h0, 32'h1);
    check_op("minint_minus_one", 32'h8000_0000, 32'h1);
    check_op("maxint_minus_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF);

    // 9 - 4 with a second request held mid-RUN and operands changed under it.
    start = 1'b1; a = 32'd9; b = 32'd4;
    @(negedge clock); start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1; a = 32'd100; b = 32'd1;
    repeat (10) @(negedge clock);
    chk("busy_mid_run", 64'(busy), 64'(1));
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        chk("diff_9_4", 64'(diff), 64'd5);
      end
    end
    chk("single_done", 64'(pulses), 64'(1));

    // Reset mid-RUN aborts with outputs cleared immediately.
    start = 1'b1; a = 32'd123; b = 32'd45;
    @(negedge clock); start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_diff", 64'(diff), 64'(0));
    chk("arst_borrow", 64'(borrow_out), 64'(0));
    chk("arst_ovf", 64'(overflow), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    chk("no_done_after_abort", 64'(pulses), 64'(0));
    check_op("seven_minus_seven", 32'd7, 32'd7);

    // Random pairs, issued back to back.
    for (int i = 0; i < 1000; i++) begin
      ra = 32'($urandom);
      rb = 32'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      check_op("rand", ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
